// File: rtl/rf_dec_pkg.sv
// Shared types and helpers for the register-file wordline controller.
package rf_dec_pkg;

    // Controller phases: clear sweep, then normal decode
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Largest register ID width the generic helpers below can handle
    localparam int unsigned MAX_ADDR_W = 8;
    localparam int unsigned MAX_DEPTH  = 1 << MAX_ADDR_W;

    // Number of registers addressed by an ID of the given width
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Single set bit at position x; callers truncate to their own DEPTH
    function automatic logic [MAX_DEPTH-1:0] onehot(input logic [MAX_ADDR_W-1:0] x);
        return {{(MAX_DEPTH-1){1'b0}}, 1'b1} << x;
    endfunction

    // LSB of read port p's ID inside the packed rd_id bus
    function automatic int unsigned id_lsb(input int unsigned port, input int unsigned addr_w);
        return port * addr_w;
    endfunction

    // LSB of read port p's wordline slice inside the packed rd_wordline bus
    function automatic int unsigned wl_lsb(input int unsigned port, input int unsigned depth);
        return port * depth;
    endfunction

    // Bit of read port p inside the packed bypass bus
    function automatic int unsigned byp_idx(input int unsigned port);
        return port;
    endfunction

endpackage

// File: rtl/rf_onehot_dec.sv
// Combinational ADDR_W-to-DEPTH one-hot decoder with enable.
module rf_onehot_dec
    import rf_dec_pkg::*;
#(
    parameter  int unsigned ADDR_W = 4,
    localparam int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] id_i,
    output logic [DEPTH-1:0]  wl_o
);

    // All-zero when disabled, otherwise exactly one bit set
    always_comb begin
        wl_o = '0;
        if (en_i) begin
            wl_o = DEPTH'(onehot(MAX_ADDR_W'(id_i)));
        end
    end

endmodule

// File: rtl/rf_wordline_ctrl.sv
// Registered read/write wordline controller with same-cycle bypass flags,
// zero-register write suppression and a post-reset clear sweep.
module rf_wordline_ctrl
    import rf_dec_pkg::*;
#(
    parameter  int unsigned ADDR_W   = 4,
    parameter  int unsigned NUM_RD   = 2,
    parameter  bit          ZERO_REG = 1'b1,
    localparam int unsigned DEPTH    = depth_of(ADDR_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_req,
    input  logic                       hold,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_id,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_id,
    output logic [NUM_RD*DEPTH-1:0]    rd_wordline,
    output logic [DEPTH-1:0]           wr_wordline,
    output logic [NUM_RD-1:0]          bypass,
    output logic                       init_clr,
    output logic                       ready
);

    // Counter is one bit wider than an ID so the last-step compare is exact
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_e                    state_q;
    logic [ADDR_W:0]           cnt_q;
    logic [NUM_RD*DEPTH-1:0]   rd_wl_q;
    logic [NUM_RD*DEPTH-1:0]   rd_wl_d;
    logic [DEPTH-1:0]          wr_wl_q;
    logic [DEPTH-1:0]          wr_wl_d;
    logic [NUM_RD-1:0]         byp_q;
    logic [NUM_RD-1:0]         byp_d;
    logic                      init_clr_q;
    logic                      ready_q;

    logic                      wr_zero;
    logic                      wr_ok;
    logic                      sweep_last;
    logic                      wr_dec_en;
    logic [ADDR_W-1:0]         wr_dec_id;

    // Write qualification and the shared write-decoder input select:
    // the sweep reuses the write decoder, driven from the counter
    always_comb begin
        wr_zero    = ZERO_REG && (wr_id == '0);
        wr_ok      = wr_en && !wr_zero;
        sweep_last = (cnt_q == CNT_LAST);
        wr_dec_en  = wr_ok;
        wr_dec_id  = wr_id;
        if (state_q == ST_INIT) begin
            wr_dec_en = 1'b1;
            wr_dec_id = cnt_q[ADDR_W-1:0];
        end
    end

    // One decoder and one bypass comparator per read port
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        localparam int unsigned ID_LSB = id_lsb(p, ADDR_W);
        localparam int unsigned WL_LSB = wl_lsb(p, DEPTH);
        localparam int unsigned BY_IDX = byp_idx(p);

        rf_onehot_dec #(
            .ADDR_W (ADDR_W)
        ) u_rd_dec (
            .en_i (rd_en[p]),
            .id_i (rd_id[ID_LSB +: ADDR_W]),
            .wl_o (rd_wl_d[WL_LSB +: DEPTH])
        );

        assign byp_d[BY_IDX] = wr_ok && rd_en[p] && (rd_id[ID_LSB +: ADDR_W] == wr_id);
    end

    rf_onehot_dec #(
        .ADDR_W (ADDR_W)
    ) u_wr_dec (
        .en_i (wr_dec_en),
        .id_i (wr_dec_id),
        .wl_o (wr_wl_d)
    );

    // Controller FSM, sweep counter and all output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rd_wl_q    <= '0;
            wr_wl_q    <= '0;
            byp_q      <= '0;
            init_clr_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    wr_wl_q    <= wr_wl_d;
                    init_clr_q <= 1'b1;
                    rd_wl_q    <= '0;
                    byp_q      <= '0;
                    ready_q    <= 1'b0;
                    cnt_q      <= cnt_q + CNT_ONE;
                    if (sweep_last) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state_q    <= ST_INIT;
                        cnt_q      <= '0;
                        rd_wl_q    <= '0;
                        wr_wl_q    <= '0;
                        byp_q      <= '0;
                        init_clr_q <= 1'b0;
                        ready_q    <= 1'b0;
                    end else begin
                        init_clr_q <= 1'b0;
                        ready_q    <= 1'b1;
                        if (hold) begin
                            // Read side frozen; the write was already issued
                            wr_wl_q <= '0;
                        end else begin
                            rd_wl_q <= rd_wl_d;
                            wr_wl_q <= wr_wl_d;
                            byp_q   <= byp_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rd_wordline = rd_wl_q;
    assign wr_wordline = wr_wl_q;
    assign bypass      = byp_q;
    assign init_clr    = init_clr_q;
    assign ready       = ready_q;

endmodule
